// File: rtl/block_config_sram.sv
`default_nettype none
// ============================================================================
// Module   : block_config_sram
// Brief    : LUT truth-table storage, loaded whole in one edge, read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module block_config_sram #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2 ** ADDR_BITS
) (
    input  logic                 config_clk,
    input  logic                 config_rst_n,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 out,
    input  logic                 config_en,
    input  logic [MEM_SIZE-1:0]  config_in
);

    logic [MEM_SIZE-1:0] r_mem;

    // Full-table replacement only; there is no per-entry write path.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            r_mem <= '0;
        end else if (config_en) begin
            r_mem <= config_in;
        end
    end

    assign out = r_mem[addr];

endmodule
`default_nettype wire

// File: tb/tb_block_config_sram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_block_config_sram
// Brief    : Directed self-checking bench for block_config_sram (ADDR_BITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_config_sram;

    localparam int ADDR_BITS = 4;
    localparam int MEM_SIZE  = 16;

    logic                 config_clk;
    logic                 config_rst_n;
    logic [ADDR_BITS-1:0] addr;
    logic                 out;
    logic                 config_en;
    logic [MEM_SIZE-1:0]  config_in;
    logic                 clk_run;

    int test_count;
    int fail_count;

    block_config_sram #(
        .ADDR_BITS(ADDR_BITS),
        .MEM_SIZE (MEM_SIZE)
    ) u_dut (
        .config_clk  (config_clk),
        .config_rst_n(config_rst_n),
        .addr        (addr),
        .out         (out),
        .config_en   (config_en),
        .config_in   (config_in)
    );

    // Clock can be frozen to prove reads and reset need no edges.
    always begin
        #5;
        if (clk_run) config_clk = ~config_clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic load(input logic [MEM_SIZE-1:0] val);
        @(negedge config_clk);
        config_in = val;
        config_en = 1'b1;
        @(negedge config_clk);
        config_en = 1'b0;
    endtask

    task automatic sweep(input string tag, input logic [MEM_SIZE-1:0] table_val);
        for (int a = 0; a < MEM_SIZE; a++) begin
            addr = a[ADDR_BITS-1:0];
            #1;
            check($sformatf("%s addr=%0d", tag, a), out, table_val[a]);
        end
    endtask

    task automatic spot(input string tag, input int a, input logic exp);
        addr = a[ADDR_BITS-1:0];
        #1;
        check($sformatf("%s addr=%0d", tag, a), out, exp);
    endtask

    initial begin
        logic [MEM_SIZE-1:0] zero_tbl;
        logic [MEM_SIZE-1:0] xor_tbl;
        test_count   = 0;
        fail_count   = 0;
        zero_tbl     = '0;
        config_clk   = 1'b0;
        clk_run      = 1'b0;
        config_rst_n = 1'b0;
        config_en    = 1'b0;
        config_in    = '0;
        addr         = '0;

        // Reset with the clock stopped.
        #2;
        sweep("reset", zero_tbl);

        clk_run = 1'b1;
        @(negedge config_clk);
        config_rst_n = 1'b1;
        @(negedge config_clk);
        sweep("post_reset", zero_tbl);

        // AND table.
        load(16'h8000);
        sweep("and", 16'h8000);

        // XOR table compared against the parity of each address.
        load(16'h6996);
        for (int a = 0; a < MEM_SIZE; a++) xor_tbl[a] = ^a[ADDR_BITS-1:0];
        sweep("xor", xor_tbl);
        spot("xor_spot", 0, 1'b0);
        spot("xor_spot", 1, 1'b1);
        spot("xor_spot", 3, 1'b0);
        spot("xor_spot", 7, 1'b1);

        // Hold: config_in ignored while config_en is low.
        load(16'h00FF);
        config_in = 16'hFF00;
        repeat (5) @(posedge config_clk);
        #1;
        spot("hold", 0, 1'b1);
        spot("hold", 8, 1'b0);
        sweep("hold_all", 16'h00FF);

        // Back-to-back loads; last wins. Then read with the clock frozen.
        @(negedge config_clk);
        config_in = 16'hFFFF;
        config_en = 1'b1;
        @(negedge config_clk);
        config_in = 16'h0001;
        @(negedge config_clk);
        config_en = 1'b0;
        clk_run   = 1'b0;
        sweep("reload_noclk", 16'h0001);
        clk_run = 1'b1;

        // Async reset pulse between edges.
        load(16'hFFFF);
        addr = 4'd5;
        #1;
        check("preasync addr=5", out, 1'b1);
        config_rst_n = 1'b0;
        #1;
        check("async_drop addr=5", out, 1'b0);
        config_rst_n = 1'b1;
        #1;
        check("async_still addr=5", out, 1'b0);
        repeat (3) @(posedge config_clk);
        #1;
        sweep("after_async", zero_tbl);

        // Reset held across a load edge wins.
        load(16'hA5A5);
        sweep("preload", 16'hA5A5);
        @(negedge config_clk);
        config_in    = 16'hFFFF;
        config_en    = 1'b1;
        config_rst_n = 1'b0;
        @(posedge config_clk);
        #1;
        sweep("rst_vs_load", zero_tbl);
        @(negedge config_clk);
        config_en    = 1'b0;
        config_rst_n = 1'b1;
        @(negedge config_clk);
        load(16'h1234);
        sweep("final", 16'h1234);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        fail_count++;
        $display("FAIL timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
